psum_acc_sfp: RTL and testbench

Per-column accumulator directly downstream of the 2-bit/4-bit MAC array. It consumes the signed partial sums from the bottom row of a MAC column and accumulates a programmable number of them into one output. It presents each result on a valid/ready port toward the output SRAM writer. Accumulation saturates; an optional ReLU is applied on the output.

---
 rtl/psum_acc_pkg.sv | 27 ++
 rtl/sat_add.sv | 33 +++
 rtl/psum_acc_sfp.sv | 107 ++++++++++
 tb/tb_psum_acc_sfp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the per-column partial-sum accumulator.
// Optional feature macro used by the top: PSUM_ACC_RELU_EN.
package psum_acc_pkg;

    // Controller states: waiting for start, accumulating a window, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Largest signed value representable in bw bits.
    function automatic logic signed [63:0] acc_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in bw bits.
    function automatic logic signed [63:0] acc_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    // A window length of zero is treated as a window of one psum.
    function automatic logic [31:0] len_clamp(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder: sum clamps to the acc_bw signed
// range and sat reports that a clamp happened.
module sat_add
    import psum_acc_pkg::*;
#(
    parameter int acc_bw = 20
) (
    input  logic signed [acc_bw-1:0] a,
    input  logic signed [acc_bw-1:0] b,
    output logic signed [acc_bw-1:0] sum,
    output logic                     sat
);

    localparam logic signed [63:0]       max_w = acc_max(acc_bw);
    localparam logic signed [63:0]       min_w = acc_min(acc_bw);
    localparam logic signed [acc_bw-1:0] max_v = max_w[acc_bw-1:0];
    localparam logic signed [acc_bw-1:0] min_v = min_w[acc_bw-1:0];

    logic [acc_bw:0] full;

    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        full = {a[acc_bw-1], a} + {b[acc_bw-1], b};
        sum  = full[acc_bw-1:0];
        sat  = 1'b0;
        if (full[acc_bw] != full[acc_bw-1]) begin
            sat = 1'b1;
            sum = full[acc_bw] ? min_v : max_v;
        end
    end

endmodule

// File: rtl/psum_acc_sfp.sv
// Per-column psum accumulator: sums cfg_len signed psums per window with
// saturation and presents each result on a valid/ready port.
// Build option: define PSUM_ACC_RELU_EN to clamp negative results to zero.
module psum_acc_sfp
    import psum_acc_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20,
    parameter int len_bw  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [len_bw-1:0]        cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [psum_bw-1:0] in_psum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [acc_bw-1:0] out_data,
    output logic                     busy,
    output logic                     sat_flag
);

    state_t                   state;
    logic [len_bw-1:0]        len_q;
    logic [len_bw-1:0]        cnt;
    logic signed [acc_bw-1:0] acc;
    logic signed [acc_bw-1:0] psum_ext;
    logic signed [acc_bw-1:0] nxt;
    logic signed [acc_bw-1:0] result;
    logic                     add_sat;
    logic                     last;

    // Signed size cast sign-extends the psum to accumulator width.
    assign psum_ext = acc_bw'(in_psum);
    assign last     = (cnt == len_q - 1'b1);

    sat_add #(.acc_bw(acc_bw)) u_sat_add (
        .a   (acc),
        .b   (psum_ext),
        .sum (nxt),
        .sat (add_sat)
    );

`ifdef PSUM_ACC_RELU_EN
    assign result = nxt[acc_bw-1] ? '0 : nxt;
`else
    assign result = nxt;
`endif

    // Window FSM with counter, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= len_bw'(1);
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (start) begin
            // Start wins over any transfer on the same edge and drops a pending result.
            state     <= ACC;
            len_q     <= len_bw'(len_clamp(32'(cfg_len)));
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid && in_ready) begin
                        if (add_sat) sat_flag <= 1'b1;
                        if (last) begin
                            out_data  <= result;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc <= nxt;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE: inputs are ignored until start.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_sfp.sv
// Self-checking bench for psum_acc_sfp: directed scenarios plus randomized
// windows compared against a plain-arithmetic window model.
module tb_psum_acc_sfp;

    localparam int PSUM_BW = 16;
    localparam int ACC_BW  = 20;
    localparam int LEN_BW  = 6;
    localparam longint MAXV = (64'sd1 <<< (ACC_BW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_BW - 1));

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      start = 1'b0;
    logic [LEN_BW-1:0]         cfg_len = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [PSUM_BW-1:0] in_psum = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic signed [ACC_BW-1:0]  out_data;
    logic                      busy;
    logic                      sat_flag;

    int n_tests = 0;
    int n_fail  = 0;

    psum_acc_sfp #(.psum_bw(PSUM_BW), .acc_bw(ACC_BW), .len_bw(LEN_BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    // Reference: add each psum with clamping to the acc range, optional ReLU on the result.
    function automatic longint model_out(input int vals[$], output bit sat);
        longint s = 0;
        sat = 1'b0;
        foreach (vals[i]) begin
            s = s + vals[i];
            if (s > MAXV) begin s = MAXV; sat = 1'b1; end
            if (s < MINV) begin s = MINV; sat = 1'b1; end
        end
`ifdef PSUM_ACC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic logic [ACC_BW-1:0] to_acc(input longint v);
        return v[ACC_BW-1:0];
    endfunction

    task automatic do_start(input int len);
        @(negedge clk);
        start   = 1'b1;
        cfg_len = LEN_BW'(len);
        @(posedge clk);
        #1;
        start   = 1'b0;
        cfg_len = LEN_BW'($urandom);
    endtask

    // Drive psums; a transfer happens at the posedge after a negedge where in_ready was seen.
    task automatic feed(input int vals[$], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < vals.size() && guard < 400) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_psum  = PSUM_BW'(vals[i]);
            if (in_valid && in_ready) i++;
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (i < vals.size()) begin
            n_tests++; n_fail++;
            $display("FAIL feed_timeout: accepted %0d required %0d", i, vals.size());
        end
    endtask

    task automatic check_window(input string name, input int vals[$]);
        bit     sat;
        longint e = model_out(vals, sat);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== to_acc(e) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b data=%0d in_ready=%b required valid=1 data=%0d in_ready=0",
                     name, out_valid, out_data, in_ready, e);
        end
        n_tests++;
        if (sat_flag !== sat) begin
            n_fail++;
            $display("FAIL %s_sat: sat_flag=%b required %b", name, sat_flag, sat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_tests++;
        if ({out_valid, in_ready, busy, sat_flag} !== 4'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b busy=%b sat=%b data=%0d required all 0",
                     out_valid, in_ready, busy, sat_flag, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        do_start(4);
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_state: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        feed('{3, -1, 10, 5}, 1'b0);
        check_window("basic", '{3, -1, 10, 5});
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_start(4);
        feed('{3, -1, 10, 5}, 1'b0);
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== to_acc(17) || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: valid=%b data=%0d ready=%b required 1 17 0",
                         out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        feed('{1, 2, 3, 4}, 1'b0);
        check_window("next_window", '{1, 2, 3, 4});
    endtask

    task automatic test_saturation();
        int vals[$];
        out_ready = 1'b1;
        repeat (63) vals.push_back(32767);
        do_start(63);
        feed(vals, 1'b0);
        check_window("saturation", vals);
        n_tests++;
        if (out_data !== to_acc(MAXV)) begin
            n_fail++;
            $display("FAIL saturation_max: data=%0d required %0d", out_data, MAXV);
        end
        do_start(2);
        n_tests++;
        if (sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: sat_flag=%b required 0", sat_flag);
        end
    endtask

    task automatic test_negative();
        longint e;
`ifdef PSUM_ACC_RELU_EN
        e = 0;
`else
        e = -3;
`endif
        do_start(2);
        feed('{-5, 2}, 1'b0);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== to_acc(e)) begin
            n_fail++;
            $display("FAIL negative: valid=%b data=%0d required 1 %0d", out_valid, out_data, e);
        end
    endtask

    task automatic test_async_reset();
        do_start(4);
        feed('{4, 4}, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b ready=%b busy=%b required 0 0 0",
                     out_valid, in_ready, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: ready=%b valid=%b required 0 0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort_clamp();
        int v;
        out_ready = 1'b0;
        do_start(3);
        feed('{1, 2, 3}, 1'b0);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: valid=%b required 1", out_valid);
        end
        out_ready = 1'b1;
        do_start(0);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_drop: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            v = (k == 0) ? 7 : int'($urandom_range(0, 65535)) - 32768;
            feed('{v}, 1'b0);
            check_window("len_clamp", '{v});
        end
    endtask

    task automatic test_random();
        int vals[$];
        int len;
        out_ready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            len = $urandom_range(0, 10);
            vals.delete();
            for (int k = 0; k < ((len == 0) ? 1 : len); k++)
                vals.push_back(int'($urandom_range(0, 65535)) - 32768);
            if (w == 7) begin
                // Large positive run forces a clamp mid-window.
                vals.delete();
                repeat (40) vals.push_back(30000);
                vals.push_back(-32768);
                len = 41;
            end
            do_start(len);
            feed(vals, 1'b1);
            check_window("random", vals);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_negative();
        test_async_reset();
        test_abort_clamp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
